// File: rtl/tlb_walker.sv
// Fully associative TLB with round-robin refill from an in-RAM page table.
// Misses stall the requester for a walk (WALK/WAIT); bad pages park in a sticky FAULT state until flush.
module tlb_walker #(
    parameter int VADDR_W = 16,
    parameter int PADDR_W = 6,
    parameter int DATA_W  = 16,
    parameter int OFF_W   = 3,
    parameter int ENTRIES = 4,
    parameter int PT_BASE = 56,
    parameter int PT_LEN  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               req_valid,
    input  logic [VADDR_W-1:0] req_addr,
    input  logic               req_we,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               ready,
    output logic               hit,
    output logic               fault,
    input  logic               flush,
    output logic [PADDR_W-1:0] mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_q,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count,
    output logic [1:0]         dbg_state_o
);

    localparam int PPN_W = PADDR_W - OFF_W;
    localparam int VPN_W = VADDR_W - OFF_W;
    localparam int PTR_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    // Handshake: the request is taken on any rising edge where req_valid && ready.
    // While ready is low the requester must hold req_addr/req_we/req_wdata stable.

    state_e             state_q, state_d;
    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   tag_q [ENTRIES];
    logic [PPN_W-1:0]   ppn_q [ENTRIES];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [VPN_W-1:0]   req_vpn;
    logic [OFF_W-1:0]   req_off;
    logic               in_range;
    logic               lookup_hit;
    logic [PPN_W-1:0]   lookup_ppn;
    logic               fill_en;
    logic               clear_all;
    logic               ready_c;
    logic               hit_c;
    logic               mem_we_c;
    logic [PADDR_W-1:0] mem_addr_c;
    logic               unused_pte_bits;

    assign req_vpn  = req_addr[VADDR_W-1:OFF_W];
    assign req_off  = req_addr[OFF_W-1:0];
    assign in_range = (req_vpn < VPN_W'(PT_LEN));

    // Only the PTE valid bit and PPN field carry meaning.
    assign unused_pte_bits = ^mem_q[DATA_W-2:PPN_W];

    // Fills only happen on a miss, so at most one valid tag can match.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_vpn)) begin
                lookup_hit = 1'b1;
                lookup_ppn = ppn_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        vpn_d      = vpn_q;
        fault_d    = fault_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fill_en    = 1'b0;
        clear_all  = 1'b0;
        ready_c    = 1'b0;
        hit_c      = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = '0;

        if (flush) begin
            clear_all = 1'b1;
            ptr_d     = '0;
            fault_d   = 1'b0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!req_valid) begin
                        ready_c = 1'b1;
                    end else if (lookup_hit) begin
                        ready_c    = 1'b1;
                        hit_c      = 1'b1;
                        mem_addr_c = {lookup_ppn, req_off};
                        mem_we_c   = req_we;
                        if (hit_cnt_q != '1) begin
                            hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        end
                    end else if (in_range) begin
                        vpn_d   = req_vpn;
                        state_d = S_WALK;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
                S_WALK: begin
                    mem_addr_c = PADDR_W'(PT_BASE) + PADDR_W'(vpn_q);
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_q[DATA_W-1]) begin
                        fill_en = 1'b1;
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = S_IDLE;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign ready       = ready_c & resetN;
    assign hit         = hit_c & resetN;
    assign mem_we      = mem_we_c & resetN;
    assign mem_addr    = resetN ? mem_addr_c : '0;
    assign mem_wdata   = req_wdata;
    assign fault       = fault_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            vpn_q      <= '0;
            fault_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            vpn_q      <= vpn_d;
            fault_q    <= fault_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[ptr_q] <= 1'b1;
            tag_q[ptr_q]   <= vpn_q;
            ppn_q[ptr_q]   <= mem_q[PPN_W-1:0];
        end
    end

endmodule

// File: doc/tlb_walker.md
Name: tlb_walker

Overview:
- Parametrised, fully associative TLB with hardware page-table walk; successor to the fixed combinational 16-to-6-bit translator.
- Sits between processor and single-port synchronous RAM (registered address, unregistered q).
- Hit: forwards access to RAM in the same cycle. Miss: stalls processor, reads PTE from RAM, refills an entry (round-robin), then retries.
- Out-of-range or invalid pages raise a sticky fault; keeps saturating hit/miss counters.

Parameters:
VADDR_W, 16, processor (virtual) address width
PADDR_W, 6, physical RAM address width
DATA_W, 16, data word width
OFF_W, 3, page-offset bits (PPN_W = PADDR_W-OFF_W, VPN_W = VADDR_W-OFF_W)
ENTRIES, 4, TLB entries (power of 2, >=2)
PT_BASE, 56, physical word address of page table
PT_LEN, 8, number of page-table entries (PT_BASE+PT_LEN <= 2^PADDR_W)
CNT_W, 16, hit/miss counter width

Ports:
clock  in  1  sole clock, rising edge
resetN  in  1  asynchronous active-low reset
req_valid  in  1  processor access request
req_addr  in  VADDR_W  virtual address
req_we  in  1  write enable for request
req_wdata  in  DATA_W  write data
ready  out  1  request accepted this cycle (low = stall)
hit  out  1  req_valid and TLB hit this cycle
fault  out  1  sticky translation fault
flush  in  1  invalidate all entries, clear fault
mem_addr  out  PADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data (= req_wdata)
mem_q  in  DATA_W  RAM read data; PTE format: bit DATA_W-1 = valid, bits PPN_W-1:0 = PPN
hit_count  out  CNT_W  saturating count of accepted hits
miss_count  out  CNT_W  saturating count of walks started

Behaviour:
- Reset (resetN=0, async): all entries invalid, victim ptr=0, state IDLE, fault=0, counters=0. Outputs ready=0, hit=0, mem_we=0, mem_addr=0.
- Lookup is combinational: vpn=req_addr[VADDR_W-1:OFF_W] compared against all valid entry tags (full VPN_W). At most one entry matches by construction.
- States: IDLE, WALK, WAIT, FAULT.
- IDLE, no req: ready=1, mem_we=0, mem_addr=0.
- IDLE, req hit: ready=1, hit=1, mem_addr={ppn, req_addr[OFF_W-1:0]}, mem_we=req_we; hit_count++.
- IDLE, req miss, vpn<PT_LEN: ready=0, mem_we=0; miss_count++; next WALK.
- IDLE, req miss, vpn>=PT_LEN: ready=0; fault set; next FAULT (no RAM access).
- WALK: mem_addr=PT_BASE+vpn (PADDR_W bits), mem_we=0, ready=0; next WAIT. vpn is latched in IDLE; req inputs must hold stable while ready=0.
- WAIT: mem_q holds the PTE, ready=0.
  - PTE valid: write {tag=vpn, ppn=mem_q[PPN_W-1:0], valid} into entry[ptr]; ptr=(ptr+1) mod ENTRIES; next IDLE.
  - PTE invalid: no fill; fault set; next FAULT.
- Miss penalty: ready low for 3 cycles; the retry hits in the 4th cycle.
- FAULT: ready=0, mem_we=0, fault=1; leaves only on flush or reset.
- flush (any state): at the clock edge, all entries invalid, ptr=0, fault=0, next IDLE. Any walk in progress is aborted with no fill. During a flush cycle ready=0, hit=0, mem_we=0, and counters do not change.
- Counters saturate at all-ones (no wrap).
- Replacement is strictly round-robin; it ignores validity and recency.

Test Plan:
1. Reset mid-walk: assert resetN=0 while in WAIT -> ready=0, mem_we=0, fault=0, counters 0. After release, the same request walks again (miss_count=1).
2. PT[57]=0x8005, req_valid=1, req_addr=0x000A, req_we=0:
   - mem_addr=57 during WALK; ready low 3 cycles.
   - Cycle 4: hit=1, ready=1, mem_addr=42; miss_count=1, hit_count=1.
3. Write hit: after scenario 2, req_addr=0x000B, req_we=1, req_wdata=0x1234 -> same cycle mem_addr=43, mem_we=1, mem_wdata=0x1234, ready=1.
4. Replacement: fill VPNs 0,1,2,3 (all PTEs valid), then access VPN 4 -> entry 0 replaced; re-access VPN 0 -> miss (miss_count=6).
5. Faults:
   - req_addr=0x0040 (vpn 8 >= PT_LEN) -> fault=1 next cycle, no mem_addr=PT access, ready stays 0.
   - PT[58]=0x0003 with vpn 2 -> fault after WAIT.
   - flush -> fault=0, ready=1 next cycle.
6. Flush during WALK -> no fill; the next request to the same VPN misses again. Driving hit_count to 0xFFFF then one more hit -> stays 0xFFFF.
